// File: rtl/vram_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// vram_arb_pkg
// Shared types and constants for the VRAM port arbiter.
//   win_state_t  : display window state (visible area vs vertical blank)
//   V_ACTIVE_DEF : first non-visible line of a 640x480 frame
//   FRAME_CNT_W  : width of the free-running frame counter
// -----------------------------------------------------------------------------
package vram_arb_pkg;

   typedef enum logic {
      WIN_ACTIVE = 1'b0,
      WIN_VBLANK = 1'b1
   } win_state_t;

   localparam int V_ACTIVE_DEF = 480;
   localparam int FRAME_CNT_W  = 16;

endpackage

// File: rtl/vram_port_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin picker: grants the first set request at or after
// the pointer, wrapping modulo NUM_WR.
// Ports:
//   req  in  NUM_WR  request vector
//   ptr  in  PTR_W   highest-priority index this cycle
//   gnt  out NUM_WR  one-hot grant (all zero when req is zero)
//   idx  out PTR_W   index of the granted requester
//   any  out 1       some requester was granted
// -----------------------------------------------------------------------------
module rr_arbiter #(
   parameter int NUM_WR = 4,
   parameter int PTR_W  = $clog2(NUM_WR)
) (
   input  logic [NUM_WR-1:0] req,
   input  logic [PTR_W-1:0]  ptr,
   output logic [NUM_WR-1:0] gnt,
   output logic [PTR_W-1:0]  idx,
   output logic              any
);

   logic [PTR_W-1:0] cand;

   // Scan requesters starting at ptr; the first hit wins.
   always_comb begin
      gnt  = '0;
      idx  = '0;
      any  = 1'b0;
      cand = '0;
      for (int k = 0; k < NUM_WR; k++) begin
         cand = PTR_W'((int'(ptr) + k) % NUM_WR);
         if (!any && req[cand]) begin
            any       = 1'b1;
            gnt[cand] = 1'b1;
            idx       = cand;
         end else begin
            any = any;
         end
      end
   end

endmodule

// File: rtl/vram_port_arbiter.sv
// -----------------------------------------------------------------------------
// vram_port_arbiter
// Shares the single sprite/frame RAM port between the VGA pixel fetch path and
// NUM_WR game-logic writers. Display reads always win; writers are served
// round-robin, and with FRAME_LOCK=1 only during vertical blank so a frame
// never tears.
// Ports:
//   Clk, Reset (async, active low)
//   DrawY                  current VGA line
//   disp_req/disp_addr     single-cycle display read request
//   disp_data/disp_valid   read data two cycles after disp_req
//   wr_req/wr_addr/wr_data packed per-writer requests (level, held until granted)
//   wr_gnt                 combinational one-hot grant
//   ram_addr/ram_we/ram_wdata  registered RAM port, ram_rdata its 1-cycle read data
//   frame_tick/frame_cnt   vblank-entry pulse and frame counter
//   missed/clr_missed      sticky "writer starved through a whole vblank"
// -----------------------------------------------------------------------------
module vram_port_arbiter
   import vram_arb_pkg::*;
#(
   parameter int NUM_WR     = 4,
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 8,
   parameter int V_ACTIVE   = V_ACTIVE_DEF,
   parameter int FRAME_LOCK = 1
) (
   input  logic                       Clk,
   input  logic                       Reset,
   input  logic [10:0]                DrawY,
   input  logic                       disp_req,
   input  logic [ADDR_W-1:0]          disp_addr,
   output logic [DATA_W-1:0]          disp_data,
   output logic                       disp_valid,
   input  logic [NUM_WR-1:0]          wr_req,
   input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
   input  logic [NUM_WR*DATA_W-1:0]   wr_data,
   output logic [NUM_WR-1:0]          wr_gnt,
   output logic [ADDR_W-1:0]          ram_addr,
   output logic                       ram_we,
   output logic [DATA_W-1:0]          ram_wdata,
   input  logic [DATA_W-1:0]          ram_rdata,
   output logic                       frame_tick,
   output logic [FRAME_CNT_W-1:0]     frame_cnt,
   output logic [NUM_WR-1:0]          missed,
   input  logic                       clr_missed
);

   localparam int          PTR_W      = $clog2(NUM_WR);
   localparam logic [10:0] V_ACTIVE_Y = 11'(V_ACTIVE);

   win_state_t             state_q, state_d;
   logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
   logic [ADDR_W-1:0]      ram_addr_q, ram_addr_d;
   logic                   ram_we_q, ram_we_d;
   logic [DATA_W-1:0]      ram_wdata_q, ram_wdata_d;
   logic [1:0]             disp_pipe_q, disp_pipe_d;
   logic                   frame_tick_q, frame_tick_d;
   logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
   logic [NUM_WR-1:0]      missed_q, missed_d;
   logic [NUM_WR-1:0]      missed_set;

   logic [NUM_WR-1:0]      arb_gnt;
   logic [PTR_W-1:0]       arb_idx;
   logic                   arb_any;
   logic                   write_ok;

   rr_arbiter #(
      .NUM_WR (NUM_WR),
      .PTR_W  (PTR_W)
   ) u_rr (
      .req (wr_req),
      .ptr (rr_ptr_q),
      .gnt (arb_gnt),
      .idx (arb_idx),
      .any (arb_any)
   );

   // Window FSM, frame counter and missed-write bookkeeping.
   always_comb begin
      state_d      = state_q;
      frame_tick_d = 1'b0;
      frame_cnt_d  = frame_cnt_q;
      missed_set   = '0;
      case (state_q)
         WIN_ACTIVE: begin
            if (DrawY >= V_ACTIVE_Y) begin
               state_d      = WIN_VBLANK;
               frame_tick_d = 1'b1;
               frame_cnt_d  = frame_cnt_q + FRAME_CNT_W'(1);
            end else begin
               state_d = WIN_ACTIVE;
            end
         end
         WIN_VBLANK: begin
            // Anyone still asking when the blank closes has lost this frame.
            if (DrawY < V_ACTIVE_Y) begin
               state_d    = WIN_ACTIVE;
               missed_set = wr_req;
            end else begin
               state_d = WIN_VBLANK;
            end
         end
         default: state_d = WIN_ACTIVE;
      endcase
      // Clearing beats a same-cycle set.
      missed_d = clr_missed ? '0 : (missed_q | missed_set);
   end

   // Port arbitration: display read first, then round-robin writers.
   always_comb begin
      write_ok    = ~disp_req & ((FRAME_LOCK != 0) ? (state_q == WIN_VBLANK) : 1'b1);
      wr_gnt      = (Reset && write_ok) ? arb_gnt : '0;
      ram_addr_d  = ram_addr_q;
      ram_we_d    = 1'b0;
      ram_wdata_d = ram_wdata_q;
      rr_ptr_d    = rr_ptr_q;
      disp_pipe_d = {disp_pipe_q[0], disp_req};
      if (disp_req) begin
         ram_addr_d = disp_addr;
      end else if (write_ok && arb_any) begin
         ram_addr_d  = wr_addr[int'(arb_idx)*ADDR_W +: ADDR_W];
         ram_wdata_d = wr_data[int'(arb_idx)*DATA_W +: DATA_W];
         ram_we_d    = 1'b1;
         rr_ptr_d    = (arb_idx == PTR_W'(NUM_WR-1)) ? '0 : (arb_idx + PTR_W'(1));
      end else begin
         ram_we_d = 1'b0;
      end
   end

   // State and output registers.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q      <= WIN_ACTIVE;
         rr_ptr_q     <= '0;
         ram_addr_q   <= '0;
         ram_we_q     <= 1'b0;
         ram_wdata_q  <= '0;
         disp_pipe_q  <= 2'b00;
         frame_tick_q <= 1'b0;
         frame_cnt_q  <= '0;
         missed_q     <= '0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         ram_addr_q   <= ram_addr_d;
         ram_we_q     <= ram_we_d;
         ram_wdata_q  <= ram_wdata_d;
         disp_pipe_q  <= disp_pipe_d;
         frame_tick_q <= frame_tick_d;
         frame_cnt_q  <= frame_cnt_d;
         missed_q     <= missed_d;
      end
   end

   assign ram_addr   = ram_addr_q;
   assign ram_we     = ram_we_q;
   assign ram_wdata  = ram_wdata_q;
   assign disp_valid = disp_pipe_q[1];
   assign disp_data  = ram_rdata;
   assign frame_tick = frame_tick_q;
   assign frame_cnt  = frame_cnt_q;
   assign missed     = missed_q;

endmodule

// File: tb/tb_vram_port_arbiter.sv
module tb_vram_port_arbiter;

   localparam int NW = 4;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [10:0] DrawY;
   logic        disp_req;
   logic [15:0] disp_addr;
   logic [7:0]  disp_data;
   logic        disp_valid;
   logic [NW-1:0] wr_req;
   logic [NW*16-1:0] wr_addr;
   logic [NW*8-1:0]  wr_data;
   logic [NW-1:0] wr_gnt;
   logic [15:0] ram_addr;
   logic        ram_we;
   logic [7:0]  ram_wdata;
   logic [7:0]  ram_rdata;
   logic        frame_tick;
   logic [15:0] frame_cnt;
   logic [NW-1:0] missed;
   logic        clr_missed;

   // second instance with FRAME_LOCK=0, sharing the inputs
   logic [7:0]  nl_disp_data;
   logic        nl_disp_valid;
   logic [NW-1:0] nl_wr_gnt;
   logic [15:0] nl_ram_addr;
   logic        nl_ram_we;
   logic [7:0]  nl_ram_wdata;
   logic [7:0]  nl_ram_rdata = 8'h00;
   logic        nl_frame_tick;
   logic [15:0] nl_frame_cnt;
   logic [NW-1:0] nl_missed;

   logic [15:0] wa [NW];
   logic [7:0]  wd [NW];

   always #5 Clk = ~Clk;

   always_comb begin
      wr_addr = '0;
      wr_data = '0;
      for (int i = 0; i < NW; i++) begin
         wr_addr[i*16 +: 16] = wa[i];
         wr_data[i*8 +: 8]   = wd[i];
      end
   end

   vram_port_arbiter #(.NUM_WR(NW), .ADDR_W(16), .DATA_W(8), .V_ACTIVE(480), .FRAME_LOCK(1)) u_dut (
      .Clk(Clk), .Reset(Reset), .DrawY(DrawY), .disp_req(disp_req), .disp_addr(disp_addr),
      .disp_data(disp_data), .disp_valid(disp_valid), .wr_req(wr_req), .wr_addr(wr_addr),
      .wr_data(wr_data), .wr_gnt(wr_gnt), .ram_addr(ram_addr), .ram_we(ram_we),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .frame_tick(frame_tick),
      .frame_cnt(frame_cnt), .missed(missed), .clr_missed(clr_missed));

   vram_port_arbiter #(.NUM_WR(NW), .ADDR_W(16), .DATA_W(8), .V_ACTIVE(480), .FRAME_LOCK(0)) u_dut_nl (
      .Clk(Clk), .Reset(Reset), .DrawY(DrawY), .disp_req(disp_req), .disp_addr(disp_addr),
      .disp_data(nl_disp_data), .disp_valid(nl_disp_valid), .wr_req(wr_req), .wr_addr(wr_addr),
      .wr_data(wr_data), .wr_gnt(nl_wr_gnt), .ram_addr(nl_ram_addr), .ram_we(nl_ram_we),
      .ram_wdata(nl_ram_wdata), .ram_rdata(nl_ram_rdata), .frame_tick(nl_frame_tick),
      .frame_cnt(nl_frame_cnt), .missed(nl_missed), .clr_missed(clr_missed));

   // synchronous-read RAM behind the main instance
   bit [7:0] ram_mem [0:65535];
   always @(posedge Clk) begin
      if (ram_we) ram_mem[ram_addr] <= ram_wdata;
      ram_rdata <= ram_mem[ram_addr];
   end

   // reference model state
   bit [7:0]  m_mem [0:65535];
   bit        m_vb;
   int        m_rr;
   bit        m_tick;
   bit [15:0] m_cnt;
   bit [NW-1:0] m_missed;
   logic [NW-1:0] m_gnt;
   logic [NW-1:0] obs_gnt;
   logic [NW-1:0] obs_nl_gnt;

   logic [7:0]  rd_q [$];
   logic [23:0] wr_q [$];

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // scoreboard monitor: pops an expectation whenever the DUT presents a read or a write
   always @(negedge Clk) begin
      logic [7:0]  er;
      logic [23:0] ew;
      #3;
      if (Reset === 1'b1) begin
         if (disp_valid === 1'b1) begin
            if (rd_q.size() == 0) chk("rd_unexpected", 32'(rd_q.size()), 32'd1);
            else begin
               er = rd_q.pop_front();
               chk("disp_data", {24'd0, disp_data}, {24'd0, er});
            end
         end
         if (ram_we === 1'b1) begin
            if (wr_q.size() == 0) chk("wr_unexpected", 32'(wr_q.size()), 32'd1);
            else begin
               ew = wr_q.pop_front();
               chk("ram_addr", {16'd0, ram_addr}, {16'd0, ew[23:8]});
               chk("ram_wdata", {24'd0, ram_wdata}, {24'd0, ew[7:0]});
            end
         end
      end
   end

   // one clock of the reference model; inputs are already applied at the negedge
   task automatic step();
      logic [NW-1:0] g;
      int gi;
      int p;
      #1;
      g  = '0;
      gi = 0;
      if (Reset && !disp_req && m_vb) begin
         for (int k = 0; k < NW; k++) begin
            p = (m_rr + k) % NW;
            if (g == '0 && wr_req[p]) begin
               g[p] = 1'b1;
               gi   = p;
            end
         end
      end
      obs_gnt    = wr_gnt;
      obs_nl_gnt = nl_wr_gnt;
      m_gnt      = g;
      chk("wr_gnt", {28'd0, wr_gnt}, {28'd0, g});
      if (Reset && disp_req) rd_q.push_back(m_mem[disp_addr]);
      if (g != '0) begin
         wr_q.push_back({wa[gi], wd[gi]});
         m_mem[wa[gi]] = wd[gi];
         m_rr = (gi + 1) % NW;
      end
      @(posedge Clk);
      if (!Reset) begin
         m_vb = 0; m_rr = 0; m_tick = 0; m_cnt = 16'd0; m_missed = '0;
      end else begin
         m_tick = (!m_vb && DrawY >= 11'd480);
         if (m_tick) begin
            m_cnt = m_cnt + 16'd1;
            m_vb  = 1;
         end else if (m_vb && DrawY < 11'd480) begin
            m_vb     = 0;
            m_missed = m_missed | wr_req;
         end
         if (clr_missed) m_missed = '0;
      end
      @(negedge Clk);
      chk("frame_tick", {31'd0, frame_tick}, {31'd0, m_tick});
      chk("frame_cnt", {16'd0, frame_cnt}, {16'd0, m_cnt});
      chk("missed", {28'd0, missed}, {28'd0, m_missed});
   endtask

   initial begin
      logic [NW-1:0] e;
      int y;
      Reset = 1'b0; DrawY = 11'd490; disp_req = 1'b1; disp_addr = 16'h0001;
      wr_req = 4'b1111; clr_missed = 1'b0;
      for (int i = 0; i < NW; i++) begin wa[i] = 16'(i); wd[i] = 8'(8'h10 + i); end

      // reset held with requests active
      repeat (3) step();
      chk("rst_ram_addr", {16'd0, ram_addr}, 32'd0);
      chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
      chk("rst_ram_wdata", {24'd0, ram_wdata}, 32'd0);
      chk("rst_disp_valid", {31'd0, disp_valid}, 32'd0);
      chk("rst_wr_gnt", {28'd0, wr_gnt}, 32'd0);

      // release in the visible area: no writes allowed
      disp_req = 1'b0; DrawY = 11'd0; Reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("active_no_gnt", {28'd0, obs_gnt}, 32'd0);
      end

      // vblank entry and round-robin sequence
      DrawY = 11'd478; step();
      DrawY = 11'd479; step();
      DrawY = 11'd480; step();
      chk("tick_high", {31'd0, frame_tick}, 32'd1);
      chk("cnt_one", {16'd0, frame_cnt}, 32'd1);
      DrawY = 11'd481;
      for (int k = 0; k < 5; k++) begin
         step();
         e = 4'b0001 << (k % 4);
         chk("gnt_seq", {28'd0, obs_gnt}, {28'd0, e});
         if (k == 0) chk("tick_pulse", {31'd0, frame_tick}, 32'd0);
      end

      // display read has priority
      wr_req = 4'b0010; disp_req = 1'b1; disp_addr = 16'h0007;
      step();
      chk("rd_prio", {28'd0, obs_gnt}, 32'd0);
      chk("disp_lat1", {31'd0, disp_valid}, 32'd0);
      disp_req = 1'b0;
      step();
      chk("wr_after_rd", {28'd0, obs_gnt}, 32'h2);
      chk("disp_lat2", {31'd0, disp_valid}, 32'd1);
      wr_req = 4'b0100; wa[2] = 16'h0123; wd[2] = 8'h5A;
      step();
      wr_req = 4'b0000; disp_req = 1'b1; disp_addr = 16'h0123;
      step();
      disp_req = 1'b0;
      step();
      chk("rd_valid", {31'd0, disp_valid}, 32'd1);
      chk("rd_back", {24'd0, disp_data}, 32'h5A);

      // writer 3 starved by display reads through the end of vblank
      wr_req = 4'b1000; disp_req = 1'b1;
      foreach (e[i]) begin end
      DrawY = 11'd500; step();
      DrawY = 11'd524; step();
      DrawY = 11'd0;   step();
      chk("missed_set", {28'd0, missed}, 32'h8);
      disp_req = 1'b0; wr_req = 4'b0000; clr_missed = 1'b1; DrawY = 11'd1;
      step();
      chk("missed_clr", {28'd0, missed}, 32'd0);
      clr_missed = 1'b0;

      // FRAME_LOCK=0 instance writes whenever the display is idle
      DrawY = 11'd10; wr_req = 4'b0001;
      for (int k = 0; k < 8; k++) begin
         disp_req  = (k % 2 == 0);
         disp_addr = 16'($urandom_range(0, 15));
         step();
         chk("nl_gnt", {28'd0, obs_nl_gnt}, (k % 2 == 1) ? 32'h1 : 32'h0);
         chk("fl_nogrant", {28'd0, obs_gnt}, 32'd0);
      end
      disp_req = 1'b0; wr_req = 4'b0000;

      // randomized traffic against the model
      y = 0;
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < NW; i++) begin
            if (wr_req[i] && m_gnt[i]) begin
               if ($urandom_range(0, 1) == 0) wr_req[i] = 1'b0;
               else begin wa[i] = 16'($urandom_range(0, 15)); wd[i] = 8'($urandom); end
            end else if (!wr_req[i] && $urandom_range(0, 9) < 3) begin
               wr_req[i] = 1'b1;
               wa[i] = 16'($urandom_range(0, 15));
               wd[i] = 8'($urandom);
            end
         end
         disp_req   = ($urandom_range(0, 9) < 3);
         disp_addr  = 16'($urandom_range(0, 15));
         clr_missed = ($urandom_range(0, 99) < 3);
         if (y == 3) y = 476;
         else if (y == 483) y = 520;
         else if (y == 524) y = 0;
         else y = y + 1;
         DrawY = 11'(y);
         step();
      end

      // drain and confirm everything expected was seen
      disp_req = 1'b0; wr_req = 4'b0000; clr_missed = 1'b0;
      repeat (4) step();
      chk("rd_drain", 32'(rd_q.size()), 32'd0);
      chk("wr_drain", 32'(wr_q.size()), 32'd0);

      // reset in the middle of a granted write
      DrawY = 11'd490; step(); step();
      wr_req = 4'b1111;
      step();
      chk("gnt_before_rst", {31'd0, (obs_gnt != 4'b0000)}, 32'd1);
      chk("we_before_rst", {31'd0, ram_we}, 32'd1);
      Reset = 1'b0;
      #1;
      chk("rst_we_async", {31'd0, ram_we}, 32'd0);
      chk("rst_cnt_async", {16'd0, frame_cnt}, 32'd0);
      chk("rst_gnt_async", {28'd0, wr_gnt}, 32'd0);
      rd_q.delete();
      wr_q.delete();
      step();
      Reset = 1'b1;
      step();
      chk("cnt_restart", {16'd0, frame_cnt}, 32'd1);
      DrawY = 11'd491;
      step();
      chk("rr_restart", {28'd0, obs_gnt}, 32'h1);
      wr_req = 4'b0000;
      repeat (2) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
